// File: rtl/trws_seq_pkg.sv
// Shared types and default widths for the message passer sequencer.
package trws_seq_pkg;

  localparam int ADDR_WIDTH_DEF     = 20;
  localparam int DIM_WIDTH_DEF      = 10;
  localparam int INFLIGHT_DEPTH_DEF = 16;
  localparam int LOG2_INFLIGHT_DEF  = 4;
  localparam int PASSER_LATENCY     = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RUN,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/inflight_scoreboard.sv
// In-flight address FIFO with a parallel match against two dependency addresses.
module inflight_scoreboard
  import trws_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = INFLIGHT_DEPTH_DEF,
  parameter int LOG2_DEPTH = LOG2_INFLIGHT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  pop,
  input  logic                  dep0_en,
  input  logic [ADDR_WIDTH-1:0] dep0_addr,
  input  logic                  dep1_en,
  input  logic [ADDR_WIDTH-1:0] dep1_addr,
  output logic                  hit,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] head
);

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      occ;
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic [LOG2_DEPTH:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (LOG2_DEPTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_addr;
  end

  // occ is set/cleared on different slots except when empty or full, where one side is gated
  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        occ[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + LOG2_DEPTH'(1);
      end
      if (do_pop) begin
        occ[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + LOG2_DEPTH'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (LOG2_DEPTH+1)'(1);
        2'b01:   count <= count - (LOG2_DEPTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && ((dep0_en && (mem[i] == dep0_addr)) ||
                     (dep1_en && (mem[i] == dep1_addr))))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/message_passer_sequencer.sv
// Raster sweep issue/return sequencer for the message passer pipeline.
// state | meaning
// IDLE  | waiting for start
// SETUP | compute total and initial coordinates
// RUN   | issue pixels, stalling on in-flight neighbours or full FIFO
// DRAIN | wait for remaining returns
// DONE  | one-cycle done pulse
module message_passer_sequencer
  import trws_seq_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DIM_WIDTH      = DIM_WIDTH_DEF,
  parameter int INFLIGHT_DEPTH = INFLIGHT_DEPTH_DEF,
  parameter int LOG2_INFLIGHT  = LOG2_INFLIGHT_DEF,
  parameter int PASSER_LATENCY = trws_seq_pkg::PASSER_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  backward,
  input  logic [DIM_WIDTH-1:0]  width,
  input  logic [DIM_WIDTH-1:0]  height,
  output logic                  push,
  output logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  valid,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  if (INFLIGHT_DEPTH < PASSER_LATENCY + 2) begin : g_depth_check
    $error("INFLIGHT_DEPTH must be at least PASSER_LATENCY+2");
  end
  if ((1 << LOG2_INFLIGHT) != INFLIGHT_DEPTH) begin : g_log2_check
    $error("LOG2_INFLIGHT must equal log2(INFLIGHT_DEPTH)");
  end

  seq_state_e            state, state_nxt;
  logic                  back_r;
  logic [DIM_WIDTH-1:0]  w_r, h_r, x, y;
  logic [ADDR_WIDTH-1:0] addr, total, w_ext, h_ext, setup_total;
  logic                  x_first, x_last, y_first, y_last, last_pix;
  logic                  dep0_en, dep1_en;
  logic [ADDR_WIDTH-1:0] dep0_addr, dep1_addr, head;
  logic                  hit, full, empty, issue, pop;

  assign w_ext       = {{(ADDR_WIDTH-DIM_WIDTH){1'b0}}, w_r};
  assign h_ext       = {{(ADDR_WIDTH-DIM_WIDTH){1'b0}}, h_r};
  assign setup_total = w_ext * h_ext;

  assign x_first  = (x == '0);
  assign y_first  = (y == '0);
  assign x_last   = (x == w_r - DIM_WIDTH'(1));
  assign y_last   = (y == h_r - DIM_WIDTH'(1));
  assign last_pix = back_r ? (addr == '0) : (addr == total - ADDR_WIDTH'(1));

  // Neighbours already visited in the current sweep direction
  assign dep0_en   = back_r ? ~x_last : ~x_first;
  assign dep0_addr = back_r ? addr + ADDR_WIDTH'(1) : addr - ADDR_WIDTH'(1);
  assign dep1_en   = back_r ? ~y_last : ~y_first;
  assign dep1_addr = back_r ? addr + w_ext : addr - w_ext;

  assign issue = (state == RUN) & ~hit & ~full;
  assign pop   = valid & ~empty;

  inflight_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (INFLIGHT_DEPTH),
    .LOG2_DEPTH (LOG2_INFLIGHT)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_addr (addr),
    .pop       (pop),
    .dep0_en   (dep0_en),
    .dep0_addr (dep0_addr),
    .dep1_en   (dep1_en),
    .dep1_addr (dep1_addr),
    .hit       (hit),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ((width == '0) || (height == '0)) ? DONE : SETUP;
      SETUP:   state_nxt = RUN;
      RUN:     if (issue && last_pix) state_nxt = DRAIN;
      DRAIN:   if (empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      back_r    <= 1'b0;
      w_r       <= '0;
      h_r       <= '0;
      x         <= '0;
      y         <= '0;
      addr      <= '0;
      total     <= '0;
      push      <= 1'b0;
      push_addr <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      err       <= 1'b0;
    end else begin
      push  <= issue;
      wr_en <= pop;
      err   <= err | (valid & empty);
      if (issue) push_addr <= addr;
      if (pop)   wr_addr   <= head;

      if ((state == IDLE) && start) begin
        back_r <= backward;
        w_r    <= width;
        h_r    <= height;
      end

      if (state == SETUP) begin
        total <= setup_total;
        if (back_r) begin
          x    <= w_r - DIM_WIDTH'(1);
          y    <= h_r - DIM_WIDTH'(1);
          addr <= setup_total - ADDR_WIDTH'(1);
        end else begin
          x    <= '0;
          y    <= '0;
          addr <= '0;
        end
      end

      if (issue) begin
        if (back_r) begin
          addr <= addr - ADDR_WIDTH'(1);
          if (x_first) begin
            x <= w_r - DIM_WIDTH'(1);
            y <= y - DIM_WIDTH'(1);
          end else begin
            x <= x - DIM_WIDTH'(1);
          end
        end else begin
          addr <= addr + ADDR_WIDTH'(1);
          if (x_last) begin
            x <= '0;
            y <= y + DIM_WIDTH'(1);
          end else begin
            x <= x + DIM_WIDTH'(1);
          end
        end
      end
    end
  end

  assign done = (state == DONE);
  assign busy = (state == SETUP) || (state == RUN) || (state == DRAIN);

endmodule

// File: tb/tb_message_passer_sequencer.sv
// Randomized scoreboard bench for message_passer_sequencer with a fixed-latency passer model.
module tb_message_passer_sequencer;

  localparam int AW = 20;
  localparam int DW = 10;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst, start, backward, valid;
  logic [DW-1:0] width, height;
  logic          push, wr_en, busy, done, err;
  logic [AW-1:0] push_addr, wr_addr;

  message_passer_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .backward  (backward),
    .width     (width),
    .height    (height),
    .push      (push),
    .push_addr (push_addr),
    .valid     (valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int addr;
  } ev_t;

  ev_t exp_push[$];
  ev_t exp_wr[$];
  int  exp_done[$];
  int  pass_q[$];
  int  lat = 8;
  bit  inject = 1'b0;
  bit  done_seen = 1'b0;
  bit  busy_seen = 1'b0;
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_unexp(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Passer: returns valid exactly lat cycles after each push, plus injected spurious valids
  initial begin
    forever begin
      @(negedge clk);
      #1;
      valid = inject;
      while (pass_q.size() > 0 && pass_q[0] < cyc) void'(pass_q.pop_front());
      if (pass_q.size() > 0 && pass_q[0] == cyc) begin
        valid = 1'b1;
        void'(pass_q.pop_front());
      end
    end
  end

  initial begin : monitor
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (busy) busy_seen = 1'b1;
        if (push) begin
          pass_q.push_back(cyc + lat);
          if (exp_push.size() == 0) fail_unexp("push");
          else begin
            e = exp_push.pop_front();
            chk("push_addr", int'(push_addr), e.addr);
            chk("push_cycle", cyc, e.cyc);
          end
        end
        if (wr_en) begin
          if (exp_wr.size() == 0) fail_unexp("wr_en");
          else begin
            e = exp_wr.pop_front();
            chk("wr_addr", int'(wr_addr), e.addr);
            chk("wr_cycle", cyc, e.cyc);
          end
        end
        if (done) begin
          done_seen = 1'b1;
          chk("busy_at_done", int'(busy), 0);
          if (exp_done.size() == 0) fail_unexp("done");
          else chk("done_cycle", cyc, exp_done.pop_front());
        end
      end
    end
  end

  // Reference: raster order, greedy issue time limited by neighbour returns and FIFO occupancy
  task automatic load_model(input int back, input int w, input int h, input int s);
    int total;
    int pc[];
    int plist[$];
    int prev, a, x, y, c, lo, occ;
    total = w * h;
    prev = 0;
    if (total == 0) begin
      exp_done.push_back(s + 1);
      return;
    end
    pc = new[total];
    for (int k = 0; k < total; k++) begin
      a = (back != 0) ? total - 1 - k : k;
      x = a % w;
      y = a / w;
      lo = (k == 0) ? s + 3 : prev + 1;
      if (back == 0) begin
        if (x > 0 && pc[a-1] + lat + 2 > lo) lo = pc[a-1] + lat + 2;
        if (y > 0 && pc[a-w] + lat + 2 > lo) lo = pc[a-w] + lat + 2;
      end else begin
        if (x < w - 1 && pc[a+1] + lat + 2 > lo) lo = pc[a+1] + lat + 2;
        if (y < h - 1 && pc[a+w] + lat + 2 > lo) lo = pc[a+w] + lat + 2;
      end
      c = lo;
      occ = DEPTH;
      while (occ >= DEPTH) begin
        occ = 0;
        foreach (plist[j]) if (plist[j] <= c - 1 && c - 1 <= plist[j] + lat) occ++;
        if (occ >= DEPTH) c++;
      end
      pc[a] = c;
      plist.push_back(c);
      prev = c;
      exp_push.push_back('{c, a});
      exp_wr.push_back('{c + lat + 1, a});
    end
    exp_done.push_back(prev + lat + 2);
  endtask

  task automatic issue_start(input int back, input int w, input int h);
    int s;
    @(negedge clk);
    s = cyc;
    load_model(back, w, h, s);
    backward  = (back != 0);
    width     = DW'(w);
    height    = DW'(h);
    done_seen = 1'b0;
    busy_seen = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_sweep(input int back, input int w, input int h, input int l);
    int budget;
    lat = l;
    issue_start(back, w, h);
    budget = 0;
    while (!done_seen && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (!done_seen) fail_unexp("done_timeout");
    repeat (3) @(negedge clk);
    chk("push_queue_drained", exp_push.size(), 0);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("busy_seen", int'(busy_seen), (w * h > 0) ? 1 : 0);
    chk("err_clear", int'(err), 0);
    exp_push.delete();
    exp_wr.delete();
    exp_done.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    backward = 1'b0;
    width = '0;
    height = '0;
    valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_push", int'(push), 0);
    chk("rst_push_addr", int'(push_addr), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_sweep(0, 2, 1, 8);
    run_sweep(0, 4, 1, 8);
    run_sweep(1, 3, 2, 8);
    run_sweep(0, 0, 5, 8);
    run_sweep(0, 5, 4, 12);
    run_sweep(1, 4, 3, 12);
    for (int i = 0; i < 6; i++)
      run_sweep(int'($urandom_range(0, 1)), int'($urandom_range(1, 6)),
                int'($urandom_range(1, 5)), 8);

    // Spurious return while idle
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    chk("err_spurious", int'(err), 1);
    chk("wr_en_spurious", int'(wr_en), 0);

    // Reset in the middle of a sweep
    lat = 8;
    issue_start(0, 6, 4);
    repeat (25) @(negedge clk);
    chk("busy_mid_sweep", int'(busy), 1);
    rst = 1'b1;
    exp_push.delete();
    exp_wr.delete();
    exp_done.delete();
    @(posedge clk);
    #1;
    chk("abort_push", int'(push), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_done", int'(done), 0);
    repeat (20) @(negedge clk);
    pass_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_push", int'(push), 0);
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_err", int'(err), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
